// File: rtl/pipe_hazard_sched.sv
// pipe_hazard_sched: stage enable/clear and PC control for the 5-stage core,
// with interrupt drain, halt handling and saturating stall/flush statistics.
module pipe_hazard_sched #(
   parameter int CNT_W     = 32,
   parameter int DRAIN_CYC = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_req_a,
   input  logic [4:0]       id_req_b,
   input  logic             id_uses_a,
   input  logic             id_uses_b,
   input  logic             id_skip_load_use,
   input  logic [4:0]       ex_req_w,
   input  logic             ex_r_datamem,
   input  logic             ex_mispredict,
   input  logic             ex_halt,
   input  logic             mem_busy,
   input  logic             intr_req,
   input  logic             resume,
   output logic             pc_en,
   output logic [1:0]       pc_sel,
   output logic             ps1_en,
   output logic             ps2_en,
   output logic             ps3_en,
   output logic             ps4_en,
   output logic             ps1_clear,
   output logic             ps2_clear,
   output logic             ps3_clear,
   output logic             ps4_clear,
   output logic             intr_ack,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);
   typedef enum logic [1:0] {RUN, DRAIN, VECTOR, HALT} state_t;
   state_t state, nxt;
   logic [3:0] dcnt, dcnt_nxt;
   logic [3:0] en, clr;
   logic       load_use, flush_inc, stall_inc;

   assign load_use = ex_r_datamem && ex_req_w != 5'd0 && !id_skip_load_use &&
                     ((id_uses_a && id_req_a == ex_req_w) || (id_uses_b && id_req_b == ex_req_w));

   // en/clr bit 0 is PS1 (IF/ID) through bit 3 PS4 (MEM/WB)
   always_comb begin
      nxt       = state;
      dcnt_nxt  = dcnt;
      en        = 4'b1111;
      clr       = 4'b0000;
      pc_en     = 1'b1;
      pc_sel    = 2'd0;
      flush_inc = 1'b0;
      case (state)
         RUN:
            if (mem_busy) begin
               en    = 4'b0000;
               pc_en = 1'b0;
            end else if (ex_mispredict) begin
               pc_sel    = 2'd1;
               en        = 4'b1100;
               clr       = 4'b0011;
               flush_inc = 1'b1;
            end else if (ex_halt) begin
               pc_en = 1'b0;
               en    = 4'b1100;
               clr   = 4'b0010;
               nxt   = HALT;
            end else if (intr_req) begin
               pc_en    = 1'b0;
               en       = 4'b1110;
               clr      = 4'b0001;
               dcnt_nxt = 4'(DRAIN_CYC - 1);
               nxt      = (DRAIN_CYC == 1) ? VECTOR : DRAIN;
            end else if (load_use) begin
               pc_en = 1'b0;
               en    = 4'b1100;
               clr   = 4'b0010;
            end
         DRAIN:
            if (mem_busy) begin
               en    = 4'b0000;
               pc_en = 1'b0;
            end else begin
               // a late mispredict still redirects so the saved return PC is correct
               pc_en     = ex_mispredict;
               pc_sel    = ex_mispredict ? 2'd1 : 2'd0;
               en        = ex_mispredict ? 4'b1100 : 4'b1110;
               clr       = ex_mispredict ? 4'b0011 : 4'b0001;
               flush_inc = ex_mispredict;
               dcnt_nxt  = dcnt - 4'd1;
               nxt       = (dcnt == 4'd1) ? VECTOR : DRAIN;
            end
         VECTOR:
            if (mem_busy) begin
               en    = 4'b0000;
               pc_en = 1'b0;
            end else begin
               pc_sel = 2'd2;
               en     = 4'b1110;
               clr    = 4'b0001;
               nxt    = RUN;
            end
         HALT:
            if (resume) nxt = RUN;
            else begin
               en    = 4'b0000;
               pc_en = 1'b0;
            end
      endcase
      stall_inc = (state == RUN || state == DRAIN) && !pc_en;
      if (rst) begin
         en     = 4'b0000;
         clr    = 4'b1111;
         pc_en  = 1'b0;
         pc_sel = 2'd0;
      end
   end

   assign {ps4_en, ps3_en, ps2_en, ps1_en}             = en;
   assign {ps4_clear, ps3_clear, ps2_clear, ps1_clear} = clr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= RUN;
         dcnt      <= 4'd0;
         intr_ack  <= 1'b0;
         halted    <= 1'b0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         state    <= nxt;
         dcnt     <= dcnt_nxt;
         intr_ack <= state == VECTOR && !mem_busy;
         halted   <= nxt == HALT;
         if (stall_inc && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
         if (flush_inc && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_pipe_hazard_sched.sv
// tb_pipe_hazard_sched: directed vectors for the pipeline sequencer, CNT_W=4, DRAIN_CYC=3.
module tb_pipe_hazard_sched;
   logic       clk = 1'b0, rst = 1'b1;
   logic [4:0] id_req_a = '0, id_req_b = '0, ex_req_w = '0;
   logic       id_uses_a = 0, id_uses_b = 0, id_skip_load_use = 0;
   logic       ex_r_datamem = 0, ex_mispredict = 0, ex_halt = 0;
   logic       mem_busy = 0, intr_req = 0, resume = 0;
   logic       pc_en, ps1_en, ps2_en, ps3_en, ps4_en;
   logic       ps1_clear, ps2_clear, ps3_clear, ps4_clear;
   logic       intr_ack, halted;
   logic [1:0] pc_sel;
   logic [3:0] stall_cnt, flush_cnt, clr;
   logic [10:0] ctl;
   int total = 0, bad = 0;

   // ctl = {pc_en, pc_sel, effective stage enables (clear wins), stage clears}, bit order ps4..ps1
   localparam logic [10:0] C_DEF = 11'b1_00_1111_0000;
   localparam logic [10:0] C_FRZ = 11'b0_00_0000_0000;
   localparam logic [10:0] C_RST = 11'b0_00_0000_1111;
   localparam logic [10:0] C_LU  = 11'b0_00_1100_0010;
   localparam logic [10:0] C_MIS = 11'b1_01_1100_0011;
   localparam logic [10:0] C_DRN = 11'b0_00_1110_0001;
   localparam logic [10:0] C_VEC = 11'b1_10_1110_0001;

   pipe_hazard_sched #(.CNT_W(4), .DRAIN_CYC(3)) dut (
      .clk(clk), .rst(rst), .id_req_a(id_req_a), .id_req_b(id_req_b),
      .id_uses_a(id_uses_a), .id_uses_b(id_uses_b), .id_skip_load_use(id_skip_load_use),
      .ex_req_w(ex_req_w), .ex_r_datamem(ex_r_datamem), .ex_mispredict(ex_mispredict),
      .ex_halt(ex_halt), .mem_busy(mem_busy), .intr_req(intr_req), .resume(resume),
      .pc_en(pc_en), .pc_sel(pc_sel), .ps1_en(ps1_en), .ps2_en(ps2_en), .ps3_en(ps3_en),
      .ps4_en(ps4_en), .ps1_clear(ps1_clear), .ps2_clear(ps2_clear), .ps3_clear(ps3_clear),
      .ps4_clear(ps4_clear), .intr_ack(intr_ack), .halted(halted),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

   assign clr = {ps4_clear, ps3_clear, ps2_clear, ps1_clear};
   assign ctl = {pc_en, pc_sel, {ps4_en, ps3_en, ps2_en, ps1_en} & ~clr, clr};

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2;
      chk("rst_ctl", 32'(ctl), 32'(C_RST));
      chk("rst_stall", 32'(stall_cnt), 0);
      chk("rst_halted", 32'(halted), 0);
      chk("rst_ack", 32'(intr_ack), 0);
      tick();
      rst = 0;
      #1 chk("run_def", 32'(ctl), 32'(C_DEF));
      // T1/T2 load-use and its exemptions
      ex_r_datamem = 1; ex_req_w = 5'd8; id_req_a = 5'd8; id_uses_a = 1;
      #1 chk("lu_a", 32'(ctl), 32'(C_LU));
      tick();
      chk("lu_a_cnt", 32'(stall_cnt), 1);
      id_uses_a = 0;
      #1 chk("lu_nouse", 32'(ctl), 32'(C_DEF));
      id_req_b = 5'd8; id_uses_b = 1;
      #1 chk("lu_b", 32'(ctl), 32'(C_LU));
      tick();
      chk("lu_b_cnt", 32'(stall_cnt), 2);
      ex_req_w = 5'd0; id_req_b = 5'd0;
      #1 chk("lu_r0", 32'(ctl), 32'(C_DEF));
      ex_req_w = 5'd8; id_req_b = 5'd8; id_skip_load_use = 1;
      #1 chk("lu_skip", 32'(ctl), 32'(C_DEF));
      id_skip_load_use = 0; ex_mispredict = 1;
      #1 chk("mis_over_lu", 32'(ctl), 32'(C_MIS));
      tick();
      ex_mispredict = 0; ex_r_datamem = 0; id_uses_b = 0;
      chk("mis_flush", 32'(flush_cnt), 1);
      chk("mis_stall", 32'(stall_cnt), 2);
      // T3 plain interrupt drain
      intr_req = 1;
      #1 chk("int_run", 32'(ctl), 32'(C_DRN));
      tick();
      intr_req = 0;
      #1 chk("drain1", 32'(ctl), 32'(C_DRN));
      tick();
      #1 chk("drain2", 32'(ctl), 32'(C_DRN));
      tick();
      #1 chk("vec", 32'(ctl), 32'(C_VEC));
      chk("vec_ack0", 32'(intr_ack), 0);
      tick();
      chk("ack", 32'(intr_ack), 1);
      chk("int_stall", 32'(stall_cnt), 5);
      #1 chk("after_vec", 32'(ctl), 32'(C_DEF));
      tick();
      chk("ack_pulse", 32'(intr_ack), 0);
      // T4 mem_busy mid-drain, and in VECTOR
      intr_req = 1;
      tick();
      intr_req = 0; mem_busy = 1;
      for (int i = 0; i < 4; i++) begin
         #1 chk("drain_frz", 32'(ctl), 32'(C_FRZ));
         tick();
      end
      mem_busy = 0;
      #1 chk("drain_a", 32'(ctl), 32'(C_DRN));
      tick();
      #1 chk("drain_b", 32'(ctl), 32'(C_DRN));
      tick();
      chk("drain7_stall", 32'(stall_cnt), 12);
      #1 chk("vec2", 32'(ctl), 32'(C_VEC));
      mem_busy = 1;
      #1 chk("vec_busy", 32'(ctl), 32'(C_FRZ));
      tick();
      mem_busy = 0;
      chk("vec_busy_ack", 32'(intr_ack), 0);
      #1 chk("vec_held", 32'(ctl), 32'(C_VEC));
      tick();
      chk("ack2", 32'(intr_ack), 1);
      // mispredict during drain
      intr_req = 1;
      tick();
      intr_req = 0; ex_mispredict = 1;
      #1 chk("drain_mis", 32'(ctl), 32'(C_MIS));
      tick();
      ex_mispredict = 0;
      chk("drain_mis_flush", 32'(flush_cnt), 2);
      #1 chk("drain_after_mis", 32'(ctl), 32'(C_DRN));
      tick();
      #1 chk("vec3", 32'(ctl), 32'(C_VEC));
      tick();
      chk("drain_mis_stall", 32'(stall_cnt), 14);
      // T5 halt and resume
      ex_halt = 1;
      #1 chk("halt_run", 32'(ctl), 32'(C_LU));
      tick();
      ex_halt = 0; intr_req = 1;
      chk("halted", 32'(halted), 1);
      for (int i = 0; i < 10; i++) begin
         #1 chk("halt_frz", 32'(ctl), 32'(C_FRZ));
         tick();
      end
      chk("halt_stall", 32'(stall_cnt), 15);
      chk("still_halted", 32'(halted), 1);
      intr_req = 0; resume = 1;
      #1 chk("resume", 32'(ctl), 32'(C_DEF));
      tick();
      resume = 0;
      chk("unhalted", 32'(halted), 0);
      // T6 reset inside VECTOR, then saturation
      intr_req = 1;
      tick();
      intr_req = 0;
      tick();
      tick();
      #1 chk("vec_pre_rst", 32'(ctl), 32'(C_VEC));
      rst = 1;
      #1 chk("rst_async_ctl", 32'(ctl), 32'(C_RST));
      chk("rst_async_stall", 32'(stall_cnt), 0);
      tick();
      rst = 0;
      #1 chk("post_rst_run", 32'(ctl), 32'(C_DEF));
      chk("post_rst_ack", 32'(intr_ack), 0);
      tick();
      chk("post_rst_ack2", 32'(intr_ack), 0);
      ex_r_datamem = 1; ex_req_w = 5'd3; id_req_a = 5'd3; id_uses_a = 1;
      repeat (20) tick();
      chk("sat_stall", 32'(stall_cnt), 15);
      chk("sat_flush", 32'(flush_cnt), 0);
      #1 chk("sat_lu_ctl", 32'(ctl), 32'(C_LU));
      ex_r_datamem = 0; id_uses_a = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
